// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD command constants, top-state encoding and buffer geometry
package lcd_pkg;

  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] LINE1    = 8'h80;
  localparam logic [7:0] LINE2    = 8'hC0;

  localparam int NUM_CHARS  = 32;
  localparam int LINE_CHARS = 16;
  localparam int ADDR_W     = 5;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_LINE_CMD,
    ST_FETCH,
    ST_XFER,
    ST_IDLE
  } top_state_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = FUNC_SET;
      2'd1:    init_cmd = DISP_ON;
      2'd2:    init_cmd = CLEAR;
      default: init_cmd = ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_strobe.sv
// rtl/lcd_strobe.sv - one LCD byte transfer: setup cycle, enable pulse, post-pulse wait
module lcd_strobe #(
  parameter int EN_HIGH_CYCLES    = 25,
  parameter int CMD_WAIT_CYCLES   = 2500,
  parameter int CLEAR_WAIT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       done
);

  localparam int MAX_A   = (EN_HIGH_CYCLES > CMD_WAIT_CYCLES) ? EN_HIGH_CYCLES : CMD_WAIT_CYCLES;
  localparam int MAX_CNT = (MAX_A > CLEAR_WAIT_CYCLES) ? MAX_A : CLEAR_WAIT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(EN_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(CLEAR_WAIT_CYCLES - 1);

  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_HIGH, PH_WAIT} phase_t;

  phase_t           phase, phase_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] wait_last;
  logic             long_q;
  logic             accept;

  assign wait_last = long_q ? LONG_LAST : SHORT_LAST;
  assign busy      = (phase != PH_IDLE);
  // A new transfer may chain directly off the last wait cycle of the previous one.
  assign accept    = start && ((phase == PH_IDLE) || done);

  always_comb begin
    phase_n = phase;
    cnt_n   = cnt;
    done    = 1'b0;
    unique case (phase)
      PH_IDLE: ;
      PH_SETUP: begin
        phase_n = PH_HIGH;
        cnt_n   = '0;
      end
      PH_HIGH: begin
        if (cnt == HIGH_LAST) begin
          phase_n = PH_WAIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PH_WAIT: begin
        if (cnt == wait_last) begin
          done    = 1'b1;
          phase_n = PH_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: phase_n = PH_IDLE;
    endcase
    if (accept) begin
      phase_n = PH_SETUP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= PH_IDLE;
      cnt      <= '0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      long_q   <= 1'b0;
    end else begin
      phase  <= phase_n;
      cnt    <= cnt_n;
      lcd_en <= (phase_n == PH_HIGH);
      if (accept) begin
        lcd_data <= data;
        lcd_rs   <= rs;
        long_q   <= long_wait;
      end
    end
  end

endmodule

// File: rtl/lcd_frame_reader.sv
// rtl/lcd_frame_reader.sv - init sequence then endless refresh of a 16x2 LCD from the 32-byte buffer
module lcd_frame_reader #(
  parameter int POWERUP_CYCLES    = 750000,
  parameter int EN_HIGH_CYCLES    = 25,
  parameter int CMD_WAIT_CYCLES   = 2500,
  parameter int CLEAR_WAIT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refresh_en,
  output logic [4:0] mem_rd_addr,
  input  logic [7:0] mem_rd_data,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       init_done,
  output logic       frame_done
);

  import lcd_pkg::*;

  localparam int              PWR_W         = $clog2(POWERUP_CYCLES + 1);
  localparam logic [PWR_W-1:0] PWR_LAST     = PWR_W'(POWERUP_CYCLES);
  localparam logic [4:0]      LAST_ADDR     = 5'(NUM_CHARS - 1);
  localparam logic [4:0]      LINE_END_ADDR = 5'(LINE_CHARS - 1);

  top_state_t       state, state_n;
  logic [PWR_W-1:0] pwr_cnt;
  logic [1:0]       init_idx;
  logic [4:0]       addr;
  logic             fetch_cnt;

  logic             strb_start;
  logic             strb_rs;
  logic [7:0]       strb_data;
  logic             strb_long;
  logic             strb_busy;
  logic             strb_done;

  assign lcd_rw    = 1'b0;
  assign strb_long = !strb_rs && (strb_data == CLEAR);

  // Each transfer is launched on the edge that enters its state, so its setup
  // cycle is the first cycle of that state and transfers chain without gaps.
  always_comb begin
    state_n    = state;
    strb_start = 1'b0;
    strb_rs    = 1'b0;
    strb_data  = 8'h00;
    unique case (state)
      ST_PWR_WAIT: begin
        if (pwr_cnt == PWR_LAST) begin
          state_n    = ST_INIT;
          strb_start = 1'b1;
          strb_data  = init_cmd(2'd0);
        end
      end
      ST_INIT: begin
        if (strb_done) begin
          strb_start = 1'b1;
          if (init_idx == 2'd3) begin
            state_n   = ST_LINE_CMD;
            strb_data = LINE1;
          end else begin
            strb_data = init_cmd(init_idx + 2'd1);
          end
        end
      end
      ST_LINE_CMD: begin
        if (strb_done) begin
          state_n = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fetch_cnt) begin
          state_n    = ST_XFER;
          strb_start = 1'b1;
          strb_rs    = 1'b1;
          strb_data  = mem_rd_data;
        end
      end
      ST_XFER: begin
        if (strb_done) begin
          if (addr == LAST_ADDR) begin
            if (refresh_en) begin
              state_n    = ST_LINE_CMD;
              strb_start = 1'b1;
              strb_data  = LINE1;
            end else begin
              state_n = ST_IDLE;
            end
          end else if (addr == LINE_END_ADDR) begin
            state_n    = ST_LINE_CMD;
            strb_start = 1'b1;
            strb_data  = LINE2;
          end else begin
            state_n = ST_FETCH;
          end
        end
      end
      ST_IDLE: begin
        if (refresh_en && !strb_busy) begin
          state_n    = ST_LINE_CMD;
          strb_start = 1'b1;
          strb_data  = LINE1;
        end
      end
      default: state_n = ST_PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_PWR_WAIT;
      pwr_cnt     <= '0;
      init_idx    <= 2'd0;
      addr        <= 5'd0;
      fetch_cnt   <= 1'b0;
      mem_rd_addr <= 5'd0;
      init_done   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_PWR_WAIT) begin
        pwr_cnt <= pwr_cnt + PWR_W'(1);
      end
      if ((state == ST_INIT) && strb_done) begin
        init_idx <= init_idx + 2'd1;
        if (init_idx == 2'd3) begin
          init_done <= 1'b1;
        end
      end
      fetch_cnt <= (state == ST_FETCH) ? ~fetch_cnt : 1'b0;
      if ((state == ST_XFER) && strb_done) begin
        addr <= addr + 5'd1;
      end
      // Read address is presented on FETCH entry; coming straight from XFER it
      // must already be the incremented address.
      if ((state_n == ST_FETCH) && (state != ST_FETCH)) begin
        mem_rd_addr <= (state == ST_XFER) ? (addr + 5'd1) : addr;
      end
      frame_done <= (state == ST_XFER) && strb_done && (addr == LAST_ADDR);
    end
  end

  lcd_strobe #(
    .EN_HIGH_CYCLES   (EN_HIGH_CYCLES),
    .CMD_WAIT_CYCLES  (CMD_WAIT_CYCLES),
    .CLEAR_WAIT_CYCLES(CLEAR_WAIT_CYCLES)
  ) u_strobe (
    .clk      (clk),
    .rst      (rst),
    .start    (strb_start),
    .rs       (strb_rs),
    .data     (strb_data),
    .long_wait(strb_long),
    .lcd_en   (lcd_en),
    .lcd_rs   (lcd_rs),
    .lcd_data (lcd_data),
    .busy     (strb_busy),
    .done     (strb_done)
  );

endmodule

// File: tb/tb_lcd_frame_reader.sv
// tb/tb_lcd_frame_reader.sv - self-checking bench for lcd_frame_reader
`timescale 1ns/1ps
module tb_lcd_frame_reader;

  localparam int PW = 20;
  localparam int EH = 2;
  localparam int CW = 5;
  localparam int LW = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       refresh_en = 1'b1;
  logic [4:0] mem_rd_addr;
  logic [7:0] mem_rd_data;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, init_done, frame_done;

  logic [7:0] mem [32];
  assign mem_rd_data = mem[mem_rd_addr];

  always #5 clk = ~clk;

  lcd_frame_reader #(
    .POWERUP_CYCLES   (PW),
    .EN_HIGH_CYCLES   (EH),
    .CMD_WAIT_CYCLES  (CW),
    .CLEAR_WAIT_CYCLES(LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .refresh_en (refresh_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en),
    .init_done  (init_done),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         hi;
    int         gap;
    logic [4:0] addr;
  } xfer_t;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         gap;
  } vec_t;

  xfer_t xq[$];
  int    fd_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor: turns pin activity into transfer records and frame periods.
  logic       p_en, p_rs, chg_pend, stab_bad, have_prev;
  logic [7:0] p_data;
  logic [4:0] p_addr;
  int         hi_cnt, lo_cnt, fd_cnt;
  xfer_t      cur;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      p_en = 0; p_rs = 0; p_data = 0; p_addr = 0;
      chg_pend = 0; stab_bad = 0; have_prev = 0;
      hi_cnt = 0; lo_cnt = 0; fd_cnt = 0;
    end else begin
      if (chg_pend && !(lcd_en && !p_en)) stab_bad = 1;
      if (lcd_en && !p_en) begin
        if (have_prev) check("data_stable_over_transfer", {31'd0, stab_bad}, 0);
        stab_bad = 0;
        have_prev = 1;
        cur.data = lcd_data; cur.rs = lcd_rs; cur.gap = lo_cnt; cur.addr = mem_rd_addr;
        hi_cnt = 1;
        lo_cnt = 0;
      end else if (lcd_en) begin
        hi_cnt++;
      end else if (p_en) begin
        cur.hi = hi_cnt;
        xq.push_back(cur);
        lo_cnt = 1;
      end else begin
        lo_cnt++;
      end
      if (lcd_en && (lcd_data !== p_data || lcd_rs !== p_rs || (lcd_rs && mem_rd_addr !== p_addr)))
        stab_bad = 1;
      chg_pend = !lcd_en && (lcd_data !== p_data || lcd_rs !== p_rs);
      fd_cnt++;
      if (frame_done) begin
        fd_q.push_back(fd_cnt);
        fd_cnt = 0;
      end
      p_en = lcd_en; p_rs = lcd_rs; p_data = lcd_data; p_addr = mem_rd_addr;
    end
  end

  vec_t init_tbl[4];

  task automatic pop_xfer(output xfer_t x);
    int budget;
    budget = 2000;
    while (xq.size() == 0 && budget > 0) begin
      @(posedge clk); #2;
      budget--;
    end
    if (xq.size() == 0) begin
      check("xfer_timeout", 1, 0);
      x = '{default: 0};
    end else begin
      x = xq.pop_front();
    end
  endtask

  task automatic wait_fd(output int period);
    int budget;
    budget = 2000;
    while (fd_q.size() == 0 && budget > 0) begin
      @(posedge clk); #2;
      budget--;
    end
    if (fd_q.size() == 0) begin
      check("frame_done_timeout", 1, 0);
      period = 0;
    end else begin
      period = fd_q.pop_front();
    end
  endtask

  task automatic run_init();
    xfer_t x;
    for (int i = 0; i < 4; i++) begin
      pop_xfer(x);
      check($sformatf("init%0d_data", i), x.data, init_tbl[i].data);
      check($sformatf("init%0d_rs", i), x.rs, init_tbl[i].rs);
      check($sformatf("init%0d_en_high", i), x.hi, EH);
      check($sformatf("init%0d_gap", i), x.gap, init_tbl[i].gap);
    end
    // Popped in the first wait cycle of 0x06: init_done rises after wait completes.
    repeat (CW - 1) begin @(posedge clk); #2; end
    check("init_done_before_wait_end", init_done, 0);
    @(posedge clk); #2;
    check("init_done_after_init", init_done, 1);
  endtask

  // Expected frame: LINE1 cmd, chars 0-15, LINE2 cmd, chars 16-31, data as in buffer.
  task automatic check_frame(input int off_at, input int poke_at, input logic [7:0] poke_val,
                             input bit skip_first_gap);
    logic [7:0] snap [32];
    xfer_t      x;
    for (int i = 0; i < 32; i++) snap[i] = mem[i];
    for (int k = 0; k < 34; k++) begin
      int         ci;
      bit         is_cmd;
      logic [7:0] exp_d;
      int         exp_gap;
      is_cmd = (k == 0) || (k == 17);
      ci     = (k < 17) ? k - 1 : k - 2;
      pop_xfer(x);
      if (is_cmd) begin
        exp_d   = (k == 0) ? 8'h80 : 8'hC0;
        exp_gap = CW + 1;
      end else begin
        exp_d   = snap[ci];
        exp_gap = CW + 3;
        check($sformatf("char%0d_rd_addr", ci), x.addr, ci);
      end
      check($sformatf("xfer%0d_data", k), x.data, exp_d);
      check($sformatf("xfer%0d_rs", k), x.rs, is_cmd ? 0 : 1);
      check($sformatf("xfer%0d_en_high", k), x.hi, EH);
      if (!(k == 0 && skip_first_gap)) check($sformatf("xfer%0d_gap", k), x.gap, exp_gap);
      if (!is_cmd && ci == off_at) refresh_en = 1'b0;
      if (!is_cmd && ci == poke_at) begin
        mem[16]  = poke_val;
        snap[16] = poke_val;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lcd_en"}, lcd_en, 0);
    check({tag, "_lcd_data"}, lcd_data, 0);
    check({tag, "_lcd_rs"}, lcd_rs, 0);
    check({tag, "_lcd_rw"}, lcd_rw, 0);
    check({tag, "_mem_rd_addr"}, mem_rd_addr, 0);
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    logic [8*11-1:0] banner;
    int              per;
    int              budget;
    int              fd_before;

    init_tbl[0] = '{8'h38, 1'b0, PW + 1};
    init_tbl[1] = '{8'h0C, 1'b0, CW + 1};
    init_tbl[2] = '{8'h01, 1'b0, CW + 1};
    init_tbl[3] = '{8'h06, 1'b0, LW + 1};

    banner = "Enter Combo";
    for (int i = 0; i < 32; i++) mem[i] = 8'h20;
    for (int i = 0; i < 11; i++) mem[i] = banner[8*(10-i) +: 8];

    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;

    run_init();
    check_frame(-1, -1, 8'h00, 1'b0);
    wait_fd(per);

    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    check_frame(-1, -1, 8'h00, 1'b0);
    wait_fd(per);
    check("frame_period_random1", per, 336);

    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    check_frame(-1, 5, 8'h30, 1'b0);
    wait_fd(per);
    check("frame_period_poke", per, 336);

    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    check_frame(5, -1, 8'h00, 1'b0);
    wait_fd(per);
    check("frame_period_stop", per, 336);

    fd_before = fd_q.size();
    repeat (100) begin
      @(posedge clk); #2;
      if (lcd_en) break;
    end
    check("idle_lcd_en", lcd_en, 0);
    check("idle_no_xfers", xq.size(), 0);
    check("idle_no_frame_done", fd_q.size(), fd_before);
    check("idle_lcd_data_hold", lcd_data, mem[31]);
    check("idle_rd_addr_hold", mem_rd_addr, 31);
    check("idle_init_done", init_done, 1);

    refresh_en = 1'b1;
    check_frame(-1, -1, 8'h00, 1'b1);
    wait_fd(per);

    budget = 2000;
    while (!lcd_en && budget > 0) begin
      @(posedge clk); #2;
      budget--;
    end
    check("saw_en_before_reset", lcd_en, 1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midpulse");
    xq.delete();
    fd_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    run_init();
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    check_frame(-1, -1, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
